// File: rtl/tx_wire_sched.sv
// tx_wire_sched: shares the single USB transmit wire between the SOF generator
// (req 0), the host transmitter (req 1) and the slave transmitter (req 2).
// SOF has fixed priority; requesters 1 and 2 alternate through a round-robin
// pointer. An idle gap of GAP_CYCLES clocks follows every release.
// Optional watchdog: define TX_WIRE_SCHED_WATCHDOG_EN to revoke grants held
// for MAX_HOLD cycles and mask the offender until it drops its request.
//
// state  | meaning
// IDLE   | no grant; eligible requests are arbitrated every clock
// ACTIVE | one requester owns the wire until it drops txReq (or is revoked)
// GAP    | inter-packet gap; requests are ignored until the counter hits 0
module tx_wire_sched #(
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned MAX_HOLD   = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] txReq,
  output logic [2:0] txGnt,
  input  logic [2:0] txWEn,
  input  logic [5:0] txData,
  input  logic [2:0] txCtrl,
  input  logic       USBWireRdyIn,
  output logic       USBWireRdyOut,
  output logic       USBWireWEn,
  output logic [1:0] TxBits,
  output logic       TxCtl,
  output logic       holdErr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  // With GAP_CYCLES=0 the load value is never used (ACTIVE returns to IDLE).
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);
  localparam bit         HAS_GAP  = (GAP_CYCLES != 0);

  if (GAP_CYCLES > 15 || MAX_HOLD < 1 || MAX_HOLD > 1023) begin : g_param_check
    $error("tx_wire_sched: GAP_CYCLES or MAX_HOLD out of range");
  end

  state_e     state_q, state_d;
  logic [2:0] gnt_q, gnt_d;
  logic       rr_q, rr_d;
  logic [3:0] gap_q, gap_d;
  logic [2:0] elig;
  logic [2:0] pick;
  logic       granted_req;

`ifdef TX_WIRE_SCHED_WATCHDOG_EN
  localparam logic [9:0] HOLD_LAST = 10'(MAX_HOLD - 1);

  logic [2:0] mask_q, mask_d;
  logic [9:0] hold_q, hold_d;
  logic       herr_q, herr_d;
  logic       revoke;

  assign elig = txReq & ~mask_q;
`else
  assign elig = txReq;
`endif

  assign granted_req = |(txReq & gnt_q);

  // Priority pick: SOF first, then round-robin between host and slave.
  always_comb begin
    pick = 3'b000;
    if (elig[0]) begin
      pick = 3'b001;
    end else if (elig[1] && elig[2]) begin
      pick = rr_q ? 3'b100 : 3'b010;
    end else if (elig[1]) begin
      pick = 3'b010;
    end else if (elig[2]) begin
      pick = 3'b100;
    end
  end

  // Next-state logic: arbitration, release/revoke, gap countdown.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    gap_d   = gap_q;
`ifdef TX_WIRE_SCHED_WATCHDOG_EN
    revoke  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|pick) begin
          gnt_d   = pick;
          state_d = ST_ACTIVE;
          if (pick[1]) begin
            rr_d = 1'b1;
          end else if (pick[2]) begin
            rr_d = 1'b0;
          end
        end
      end
      ST_ACTIVE: begin
`ifdef TX_WIRE_SCHED_WATCHDOG_EN
        revoke = granted_req && (hold_q == HOLD_LAST);
        if (!granted_req || revoke) begin
`else
        if (!granted_req) begin
`endif
          gnt_d = 3'b000;
          if (HAS_GAP) begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 3'b000;
      end
    endcase
  end

`ifdef TX_WIRE_SCHED_WATCHDOG_EN
  // Hold counter runs only while staying in ACTIVE; mask latches offenders
  // and each bit clears once its requester lets go of txReq.
  always_comb begin
    hold_d = 10'd0;
    if (state_q == ST_ACTIVE && state_d == ST_ACTIVE) begin
      hold_d = hold_q + 10'd1;
    end
    mask_d = (mask_q & txReq) | (revoke ? gnt_q : 3'b000);
    herr_d = revoke;
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= 10'd0;
      mask_q <= 3'b000;
      herr_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      mask_q <= mask_d;
      herr_q <= herr_d;
    end
  end

  assign holdErr = herr_q;
`else
  assign holdErr = 1'b0;
`endif

  // Scheduler state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 3'b000;
      rr_q    <= 1'b0;
      gap_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
    end
  end

  // Wire mux driven from the registered one-hot grant; all zero when idle.
  always_comb begin
    USBWireWEn = 1'b0;
    TxBits     = 2'b00;
    TxCtl      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (gnt_q[i]) begin
        USBWireWEn = USBWireWEn | txWEn[i];
        TxBits     = TxBits | txData[2*i +: 2];
        TxCtl      = TxCtl | txCtrl[i];
      end
    end
  end

  assign txGnt         = gnt_q;
  assign USBWireRdyOut = USBWireRdyIn;

endmodule

// File: tb/tb_tx_wire_sched.sv
// Scoreboarded bench for tx_wire_sched. dut0 uses GAP_CYCLES=4, dut1 uses
// GAP_CYCLES=0; both use MAX_HOLD=8. Stimulus pushes every expected grant
// change (edge number plus mux outputs); the monitor pops one entry per
// observed txGnt change.
module tb_tx_wire_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1;
  logic [2:0] txReq, txWEn, txCtrl;
  logic [5:0] txData;
  logic       rdy_in;

  logic [2:0] gnt0, gnt1;
  logic       rdyo0, rdyo1, wen0, wen1, ctl0, ctl1, herr0, herr1;
  logic [1:0] bits0, bits1;

  tx_wire_sched #(.GAP_CYCLES(4), .MAX_HOLD(8)) dut0 (
    .clk(clk), .rst(rst0), .txReq(txReq), .txGnt(gnt0), .txWEn(txWEn),
    .txData(txData), .txCtrl(txCtrl), .USBWireRdyIn(rdy_in),
    .USBWireRdyOut(rdyo0), .USBWireWEn(wen0), .TxBits(bits0), .TxCtl(ctl0),
    .holdErr(herr0)
  );

  tx_wire_sched #(.GAP_CYCLES(0), .MAX_HOLD(8)) dut1 (
    .clk(clk), .rst(rst1), .txReq(txReq), .txGnt(gnt1), .txWEn(txWEn),
    .txData(txData), .txCtrl(txCtrl), .USBWireRdyIn(rdy_in),
    .USBWireRdyOut(rdyo1), .USBWireWEn(wen1), .TxBits(bits1), .TxCtl(ctl1),
    .holdErr(herr1)
  );

  typedef struct packed {
    logic [15:0] edge_n;
    logic [2:0]  gnt;
    logic        wen;
    logic [1:0]  bits;
    logic        ctl;
    logic [7:0]  tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int edges = 0;
  int n_tests = 0;
  int n_fail = 0;

  always @(posedge clk) edges <= edges + 1;

  function automatic exp_t mk(input int e, input logic [2:0] g, input logic w,
                              input logic [1:0] b, input logic c, input int t);
    exp_t r;
    r.edge_n = e[15:0];
    r.gnt    = g;
    r.wen    = w;
    r.bits   = b;
    r.ctl    = c;
    r.tag    = t[7:0];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mon_cmp(input string dut, input exp_t e, input logic [2:0] g,
                         input logic w, input logic [1:0] b, input logic c);
    n_tests++;
    if (edges[15:0] !== e.edge_n || g !== e.gnt || w !== e.wen || b !== e.bits || c !== e.ctl) begin
      n_fail++;
      $display("FAIL %s ev%0d: got edge=%0d gnt=%b wen=%b bits=%b ctl=%b, expected edge=%0d gnt=%b wen=%b bits=%b ctl=%b",
               dut, e.tag, edges, g, w, b, c, e.edge_n, e.gnt, e.wen, e.bits, e.ctl);
    end
  endtask

  // Monitor: every change of txGnt must match the head of that DUT's queue.
  logic [2:0] last0 = 3'b000;
  logic [2:0] last1 = 3'b000;
  initial begin
    forever begin
      @(negedge clk);
      if (gnt0 !== last0) begin
        if (q0.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dut0 unexpected grant change: got %b at edge %0d, expected no change", gnt0, edges);
        end else begin
          mon_cmp("dut0", q0.pop_front(), gnt0, wen0, bits0, ctl0);
        end
        last0 = gnt0;
      end
      if (gnt1 !== last1) begin
        if (q1.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dut1 unexpected grant change: got %b at edge %0d, expected no change", gnt1, edges);
        end else begin
          mon_cmp("dut1", q1.pop_front(), gnt1, wen1, bits1, ctl1);
        end
        last1 = gnt1;
      end
    end
  end

  int n;

  initial begin
    rst0 = 1'b0; rst1 = 1'b0;
    txReq = '0; txWEn = '0; txData = '0; txCtrl = '0; rdy_in = 1'b0;

    // Reset values
    tick(3);
    check("rst_gnt", 32'(gnt0), 32'h0);
    check("rst_wen", 32'(wen0), 32'h0);
    check("rst_bits", 32'(bits0), 32'h0);
    check("rst_ctl", 32'(ctl0), 32'h0);
    check("rst_herr", 32'(herr0), 32'h0);
    check("rst_gnt1", 32'(gnt1), 32'h0);
    rdy_in = 1'b1; #1;
    check("rdy_copy_hi", 32'(rdyo0), 32'h1);
    check("rdy_copy_hi1", 32'(rdyo1), 32'h1);
    rdy_in = 1'b0; #1;
    check("rdy_copy_lo", 32'(rdyo0), 32'h0);
    rst0 = 1'b1;
    tick(2);
    check("post_rst_gnt", 32'(gnt0), 32'h0);

    // Round-robin between host and slave, gap of 4, request held through GAP
    txWEn = 3'b110; txData = 6'b10_01_11; txCtrl = 3'b100;
    n = edges; txReq = 3'b110;
    q0.push_back(mk(n + 1, 3'b010, 1'b1, 2'b01, 1'b0, 1));
    tick(6);
    n = edges; txReq = 3'b100;
    q0.push_back(mk(n + 1, 3'b000, 1'b0, 2'b00, 1'b0, 2));
    q0.push_back(mk(n + 6, 3'b100, 1'b1, 2'b10, 1'b1, 3));
    tick(2);
    txReq = 3'b110;
    tick(7);
    n = edges; txReq = 3'b010;
    q0.push_back(mk(n + 1, 3'b000, 1'b0, 2'b00, 1'b0, 4));
    q0.push_back(mk(n + 6, 3'b010, 1'b1, 2'b01, 1'b0, 5));
    tick(8);
    n = edges; txReq = 3'b000;
    q0.push_back(mk(n + 1, 3'b000, 1'b0, 2'b00, 1'b0, 6));
    tick(8);

    // All three at once -> SOF; SOF leaves rrPtr alone; drop in grant cycle
    txWEn = 3'b001; txData = 6'b000010; txCtrl = 3'b001;
    n = edges; txReq = 3'b111;
    q0.push_back(mk(n + 1, 3'b001, 1'b1, 2'b10, 1'b1, 7));
    tick(3);
    txReq = 3'b110;
    q0.push_back(mk(n + 4, 3'b000, 1'b0, 2'b00, 1'b0, 8));
    q0.push_back(mk(n + 9, 3'b100, 1'b0, 2'b00, 1'b0, 9));
    tick(6);
    txReq = 3'b010;
    q0.push_back(mk(n + 10, 3'b000, 1'b0, 2'b00, 1'b0, 10));
    q0.push_back(mk(n + 15, 3'b010, 1'b0, 2'b00, 1'b0, 11));
    tick(7);
    txReq = 3'b000;
    q0.push_back(mk(n + 17, 3'b000, 1'b0, 2'b00, 1'b0, 12));
    check("herr_quiet", 32'(herr0), 32'h0);
    tick(8);

    // Long hold
    txWEn = '0; txData = '0; txCtrl = '0;
`ifdef TX_WIRE_SCHED_WATCHDOG_EN
    n = edges; txReq = 3'b010;
    q0.push_back(mk(n + 1, 3'b010, 1'b0, 2'b00, 1'b0, 13));
    tick(3);
    txReq = 3'b110;
    q0.push_back(mk(n + 9, 3'b000, 1'b0, 2'b00, 1'b0, 14));
    q0.push_back(mk(n + 15, 3'b100, 1'b0, 2'b00, 1'b0, 15));
    tick(5);
    check("herr_before", 32'(herr0), 32'h0);
    tick(1);
    check("herr_pulse", 32'(herr0), 32'h1);
    tick(1);
    check("herr_after", 32'(herr0), 32'h0);
    tick(7);
    txReq = 3'b010;
    q0.push_back(mk(n + 18, 3'b000, 1'b0, 2'b00, 1'b0, 16));
    tick(8);
    txReq = 3'b000;
    tick(2);
    txReq = 3'b010;
    q0.push_back(mk(n + 28, 3'b010, 1'b0, 2'b00, 1'b0, 17));
    tick(2);
    txReq = 3'b000;
    q0.push_back(mk(n + 30, 3'b000, 1'b0, 2'b00, 1'b0, 18));
    tick(8);
`else
    n = edges; txReq = 3'b010;
    q0.push_back(mk(n + 1, 3'b010, 1'b0, 2'b00, 1'b0, 13));
    tick(20);
    check("long_hold_herr", 32'(herr0), 32'h0);
    check("long_hold_gnt", 32'(gnt0), 32'h2);
    txReq = 3'b000;
    q0.push_back(mk(n + 21, 3'b000, 1'b0, 2'b00, 1'b0, 14));
    tick(8);
`endif

    // Asynchronous reset while requester 2 is active
    txWEn = 3'b100; txData = 6'b11_00_00; txCtrl = 3'b100;
    n = edges; txReq = 3'b100;
    q0.push_back(mk(n + 1, 3'b100, 1'b1, 2'b11, 1'b1, 20));
    tick(3);
    check("pre_rst_wen", 32'(wen0), 32'h1);
    q0.push_back(mk(n + 3, 3'b000, 1'b0, 2'b00, 1'b0, 21));
    rst0 = 1'b0; #1;
    check("async_rst_gnt", 32'(gnt0), 32'h0);
    check("async_rst_wen", 32'(wen0), 32'h0);
    txReq = 3'b110;
    #1; rst0 = 1'b1;
    q0.push_back(mk(n + 4, 3'b010, 1'b0, 2'b00, 1'b0, 22));
    tick(1);
    tick(1);
    txReq = 3'b000;
    q0.push_back(mk(n + 6, 3'b000, 1'b0, 2'b00, 1'b0, 23));
    tick(8);

    // GAP_CYCLES=0 instance
    rst0 = 1'b0;
    rst1 = 1'b1;
    txWEn = 3'b111; txData = 6'b01_10_11; txCtrl = 3'b010;
    tick(2);
    n = edges; txReq = 3'b100;
    q1.push_back(mk(n + 1, 3'b100, 1'b1, 2'b01, 1'b0, 30));
    tick(2);
    txReq = 3'b010;
    q1.push_back(mk(n + 3, 3'b000, 1'b0, 2'b00, 1'b0, 31));
    q1.push_back(mk(n + 4, 3'b010, 1'b1, 2'b10, 1'b1, 32));
    tick(3);
    txReq = 3'b000;
    q1.push_back(mk(n + 6, 3'b000, 1'b0, 2'b00, 1'b0, 33));
    tick(2);
    txReq = 3'b110;
    q1.push_back(mk(n + 8, 3'b100, 1'b1, 2'b01, 1'b0, 34));
    tick(1);
    txReq = 3'b000;
    q1.push_back(mk(n + 9, 3'b000, 1'b0, 2'b00, 1'b0, 35));
    tick(4);
    check("gap0_herr", 32'(herr1), 32'h0);

    check("q0_drained", 32'(q0.size()), 32'h0);
    check("q1_drained", 32'(q1.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
